// File: rtl/cc_speed_counter_if.sv
// Bus between the speed timebase and its surroundings: control strobes and the
// comparator flag go in, the counter value, level and tick come out.
interface cc_speed_counter_if #(
    parameter int DATAWIDTH  = 15,
    parameter int LEVELWIDTH = 3
);
    logic                  CC_SPEEDCOUNTER_enable_InHigh;
    logic                  CC_SPEEDCOUNTER_clear_InHigh;
    logic                  CC_SPEEDCOUNTER_levelup_InHigh;
    logic                  CC_SPEEDCOUNTER_T0_InLow;
    logic [DATAWIDTH-1:0]  CC_SPEEDCOUNTER_data_OutBUS;
    logic [LEVELWIDTH-1:0] CC_SPEEDCOUNTER_level_OutBUS;
    logic                  CC_SPEEDCOUNTER_tick_OutHigh;
    logic                  CC_SPEEDCOUNTER_levelmax_OutHigh;

    // Side that controls the counter (game FSM, comparator, testbench).
    modport master (
        output CC_SPEEDCOUNTER_enable_InHigh,
        output CC_SPEEDCOUNTER_clear_InHigh,
        output CC_SPEEDCOUNTER_levelup_InHigh,
        output CC_SPEEDCOUNTER_T0_InLow,
        input  CC_SPEEDCOUNTER_data_OutBUS,
        input  CC_SPEEDCOUNTER_level_OutBUS,
        input  CC_SPEEDCOUNTER_tick_OutHigh,
        input  CC_SPEEDCOUNTER_levelmax_OutHigh
    );

    // Side implemented by the counter itself.
    modport slave (
        input  CC_SPEEDCOUNTER_enable_InHigh,
        input  CC_SPEEDCOUNTER_clear_InHigh,
        input  CC_SPEEDCOUNTER_levelup_InHigh,
        input  CC_SPEEDCOUNTER_T0_InLow,
        output CC_SPEEDCOUNTER_data_OutBUS,
        output CC_SPEEDCOUNTER_level_OutBUS,
        output CC_SPEEDCOUNTER_tick_OutHigh,
        output CC_SPEEDCOUNTER_levelmax_OutHigh
    );
endinterface

// File: rtl/cc_speed_counter.sv
// Speed timebase: counts from a level-dependent preload up to all-ones, waits
// for the comparator to flag the terminal value, then reloads and emits a
// one-cycle tick. Higher levels preload higher, so the period gets shorter.
// Level requests are latched and only applied at a wrap so a period is never
// cut short mid-count.
module cc_speed_counter #(
    parameter int DATAWIDTH  = 15,
    parameter int LEVELWIDTH = 3,
    parameter int LEVELS     = 8,
    parameter int LEVEL_STEP = 4096
) (
    input  logic              CC_SPEEDCOUNTER_CLOCK_50,
    input  logic              CC_SPEEDCOUNTER_RESET_InHigh,
    cc_speed_counter_if.slave bus
);

    // Preload arithmetic is done wide enough to hold LEVELS*LEVEL_STEP before clamping.
    localparam int WIDE = DATAWIDTH + LEVELWIDTH;
    localparam logic [DATAWIDTH-1:0]  TERM          = '1;
    localparam logic [WIDE-1:0]       PRELOAD_LIMIT = WIDE'((2 ** DATAWIDTH) - 2);
    localparam logic [LEVELWIDTH-1:0] LEVEL_TOP     = LEVELWIDTH'(LEVELS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WRAP = 2'd2
    } speedState_t;

    speedState_t           stateQ, stateNext;
    logic [DATAWIDTH-1:0]  dataQ, dataNext;
    logic [LEVELWIDTH-1:0] levelQ, levelNext;
    logic                  pendingQ, pendingNext;
    logic                  tickQ, tickNext;
    logic                  levelmaxQ, levelmaxNext;
    logic                  levelupAccepted;

    // P(L) = min(L*LEVEL_STEP, T-1); never T itself, so every period has at least one count.
    function automatic logic [DATAWIDTH-1:0] preload(input logic [LEVELWIDTH-1:0] lvl);
        logic [WIDE-1:0] scaled;
        scaled = WIDE'(lvl) * WIDE'(LEVEL_STEP);
        if (scaled > PRELOAD_LIMIT) begin
            scaled = PRELOAD_LIMIT;
        end
        return scaled[DATAWIDTH-1:0];
    endfunction

    // Next-state and next-output logic; clear overrides the whole FSM.
    always_comb begin
        stateNext       = stateQ;
        dataNext        = dataQ;
        levelNext       = levelQ;
        pendingNext     = pendingQ;
        tickNext        = 1'b0;
        levelupAccepted = bus.CC_SPEEDCOUNTER_levelup_InHigh && (levelQ < LEVEL_TOP);

        if (bus.CC_SPEEDCOUNTER_clear_InHigh) begin
            stateNext   = IDLE;
            dataNext    = '0;
            levelNext   = '0;
            pendingNext = 1'b0;
        end else begin
            case (stateQ)
                IDLE: begin
                    // Park on the preload so the first period after start is full length.
                    dataNext = preload(levelQ);
                    if (levelupAccepted) begin
                        pendingNext = 1'b1;
                    end
                    if (bus.CC_SPEEDCOUNTER_enable_InHigh) begin
                        stateNext = RUN;
                    end
                end
                RUN: begin
                    if (levelupAccepted) begin
                        pendingNext = 1'b1;
                    end
                    // The comparator flag wins over enable; the extra cycle at T is intentional.
                    if (!bus.CC_SPEEDCOUNTER_T0_InLow) begin
                        stateNext = WRAP;
                    end else if (bus.CC_SPEEDCOUNTER_enable_InHigh && (dataQ != TERM)) begin
                        dataNext = dataQ + 1'b1;
                    end
                end
                WRAP: begin
                    // A pulse arriving in this very cycle still counts for this wrap.
                    if ((pendingQ || bus.CC_SPEEDCOUNTER_levelup_InHigh) && (levelQ < LEVEL_TOP)) begin
                        levelNext = levelQ + 1'b1;
                    end
                    dataNext    = preload(levelNext);
                    pendingNext = 1'b0;
                    tickNext    = 1'b1;
                    stateNext   = RUN;
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end

        levelmaxNext = (levelNext == LEVEL_TOP);
    end

    // State and output registers; reset drops everything immediately, including a pending tick.
    always_ff @(posedge CC_SPEEDCOUNTER_CLOCK_50 or posedge CC_SPEEDCOUNTER_RESET_InHigh) begin
        if (CC_SPEEDCOUNTER_RESET_InHigh) begin
            stateQ    <= IDLE;
            dataQ     <= '0;
            levelQ    <= '0;
            pendingQ  <= 1'b0;
            tickQ     <= 1'b0;
            levelmaxQ <= 1'b0;
        end else begin
            stateQ    <= stateNext;
            dataQ     <= dataNext;
            levelQ    <= levelNext;
            pendingQ  <= pendingNext;
            tickQ     <= tickNext;
            levelmaxQ <= levelmaxNext;
        end
    end

    assign bus.CC_SPEEDCOUNTER_data_OutBUS      = dataQ;
    assign bus.CC_SPEEDCOUNTER_level_OutBUS     = levelQ;
    assign bus.CC_SPEEDCOUNTER_tick_OutHigh     = tickQ;
    assign bus.CC_SPEEDCOUNTER_levelmax_OutHigh = levelmaxQ;

endmodule

// File: tb/tb_cc_speed_counter.sv
// Bench for cc_speed_counter with a 4-bit counter (T=15), 4 levels, step 2.
// The comparator flag is fed back as data != 15.
module tb_cc_speed_counter;

    logic clk;
    logic rst;

    cc_speed_counter_if #(.DATAWIDTH(4), .LEVELWIDTH(2)) bus ();

    cc_speed_counter #(
        .DATAWIDTH (4),
        .LEVELWIDTH(2),
        .LEVELS    (4),
        .LEVEL_STEP(2)
    ) dut (
        .CC_SPEEDCOUNTER_CLOCK_50    (clk),
        .CC_SPEEDCOUNTER_RESET_InHigh(rst),
        .bus                         (bus)
    );

    assign bus.CC_SPEEDCOUNTER_T0_InLow = (bus.CC_SPEEDCOUNTER_data_OutBUS != 4'd15);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int data;
        int level;
        int tick;
        int lmax;
    } expT;

    expT sb[$];
    int  nChecks = 0;
    int  nErrors = 0;

    // Reference model state: 0 idle, 1 counting, 2 wrap cycle.
    int mState, mData, mLevel, mPend;

    task automatic check(input string tag, input int unsigned act, input int unsigned exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int pre(input int lvl);
        return (lvl * 2 > 14) ? 14 : lvl * 2;
    endfunction

    function automatic void modelReset();
        mState = 0;
        mData  = 0;
        mLevel = 0;
        mPend  = 0;
        sb.delete();
    endfunction

    // Advances the model one clock and returns what the outputs should read afterwards.
    function automatic void modelStep(input logic e, input logic c, input logic l, output expT x);
        int atTerm;
        int tick;
        atTerm = (mData == 15);
        tick   = 0;
        if (c) begin
            mState = 0; mData = 0; mLevel = 0; mPend = 0;
        end else if (mState == 0) begin
            mData = pre(mLevel);
            if (l && mLevel != 3) mPend = 1;
            if (e) mState = 1;
        end else if (mState == 1) begin
            if (l && mLevel != 3) mPend = 1;
            if (atTerm) mState = 2;
            else if (e) mData = mData + 1;
        end else begin
            if ((mPend != 0 || l) && mLevel < 3) mLevel = mLevel + 1;
            mData  = pre(mLevel);
            mPend  = 0;
            tick   = 1;
            mState = 1;
        end
        x.data  = mData;
        x.level = mLevel;
        x.tick  = tick;
        x.lmax  = (mLevel == 3) ? 1 : 0;
    endfunction

    // One clock: drive inputs, queue the expected result, compare after the edge.
    task automatic step(input logic e, input logic c, input logic l);
        expT x;
        bus.CC_SPEEDCOUNTER_enable_InHigh  = e;
        bus.CC_SPEEDCOUNTER_clear_InHigh   = c;
        bus.CC_SPEEDCOUNTER_levelup_InHigh = l;
        modelStep(e, c, l, x);
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("data",     bus.CC_SPEEDCOUNTER_data_OutBUS,      x.data);
        check("level",    bus.CC_SPEEDCOUNTER_level_OutBUS,     x.level);
        check("tick",     bus.CC_SPEEDCOUNTER_tick_OutHigh,     x.tick);
        check("levelmax", bus.CC_SPEEDCOUNTER_levelmax_OutHigh, x.lmax);
    endtask

    // Counts enabled cycles until the DUT ticks; gives up after 100.
    task automatic runUntilTick(output int n);
        n = 0;
        do begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end while (!bus.CC_SPEEDCOUNTER_tick_OutHigh && n < 100);
    endtask

    task automatic waitData(input int v);
        int k;
        k = 0;
        while (bus.CC_SPEEDCOUNTER_data_OutBUS != v[3:0] && k < 100) begin
            step(1'b1, 1'b0, 1'b0);
            k++;
        end
        check("wait_data", bus.CC_SPEEDCOUNTER_data_OutBUS, v);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        bus.CC_SPEEDCOUNTER_enable_InHigh  = 1'b0;
        bus.CC_SPEEDCOUNTER_clear_InHigh   = 1'b0;
        bus.CC_SPEEDCOUNTER_levelup_InHigh = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_data",     bus.CC_SPEEDCOUNTER_data_OutBUS,      0);
        check("rst_level",    bus.CC_SPEEDCOUNTER_level_OutBUS,     0);
        check("rst_tick",     bus.CC_SPEEDCOUNTER_tick_OutHigh,     0);
        check("rst_levelmax", bus.CC_SPEEDCOUNTER_levelmax_OutHigh, 0);

        // Idle without enable: data parked at P(0), no tick.
        repeat (3) step(1'b0, 1'b0, 1'b0);

        // Level 0: first tick 18 cycles after enable, then period 17.
        runUntilTick(n);
        check("first_tick", n, 18);
        runUntilTick(n);
        check("period_l0", n, 17);

        // One levelup mid-count: period unchanged, level 1 after wrap, then period 15.
        repeat (4) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("level_before_wrap", bus.CC_SPEEDCOUNTER_level_OutBUS, 0);
        runUntilTick(n);
        check("period_lu", n + 5, 17);
        check("level_after_wrap", bus.CC_SPEEDCOUNTER_level_OutBUS, 1);
        check("reload_l1", bus.CC_SPEEDCOUNTER_data_OutBUS, 2);
        runUntilTick(n);
        check("period_l1", n, 15);

        // Three pulses in one period give a single increment.
        repeat (3) begin
            step(1'b1, 1'b0, 1'b1);
            step(1'b1, 1'b0, 1'b0);
        end
        runUntilTick(n);
        check("level_multi", bus.CC_SPEEDCOUNTER_level_OutBUS, 2);

        // One more pulse reaches the top level.
        step(1'b1, 1'b0, 1'b1);
        runUntilTick(n);
        check("level_top", bus.CC_SPEEDCOUNTER_level_OutBUS, 3);
        check("levelmax_top", bus.CC_SPEEDCOUNTER_levelmax_OutHigh, 1);

        // Pulses at the top level are ignored; period 11.
        step(1'b1, 1'b0, 1'b1);
        runUntilTick(n);
        check("period_l3_lu", n + 1, 11);
        check("level_stays", bus.CC_SPEEDCOUNTER_level_OutBUS, 3);
        runUntilTick(n);
        check("period_l3", n, 11);

        // Enable low at data 9 for 5 cycles: hold, no tick, then resume at 10.
        waitData(9);
        repeat (5) begin
            step(1'b0, 1'b0, 1'b0);
            check("hold_data", bus.CC_SPEEDCOUNTER_data_OutBUS, 9);
            check("hold_tick", bus.CC_SPEEDCOUNTER_tick_OutHigh, 0);
        end
        step(1'b1, 1'b0, 1'b0);
        check("resume_data", bus.CC_SPEEDCOUNTER_data_OutBUS, 10);

        // Clear, set pending, then clear again during WRAP: pending must be dropped.
        step(1'b1, 1'b1, 1'b0);
        check("clear_level", bus.CC_SPEEDCOUNTER_level_OutBUS, 0);
        step(1'b1, 1'b0, 1'b1);
        waitData(15);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("wrapclr_data",  bus.CC_SPEEDCOUNTER_data_OutBUS,  0);
        check("wrapclr_level", bus.CC_SPEEDCOUNTER_level_OutBUS, 0);
        check("wrapclr_tick",  bus.CC_SPEEDCOUNTER_tick_OutHigh, 0);
        runUntilTick(n);
        check("clr_first_tick", n, 18);
        check("clr_pending_dropped", bus.CC_SPEEDCOUNTER_level_OutBUS, 0);

        // Reach level 1, then reset asynchronously at data 7 between edges.
        step(1'b1, 1'b0, 1'b1);
        runUntilTick(n);
        waitData(7);
        #2;
        rst = 1'b1;
        #1;
        check("arst_data",     bus.CC_SPEEDCOUNTER_data_OutBUS,      0);
        check("arst_level",    bus.CC_SPEEDCOUNTER_level_OutBUS,     0);
        check("arst_tick",     bus.CC_SPEEDCOUNTER_tick_OutHigh,     0);
        check("arst_levelmax", bus.CC_SPEEDCOUNTER_levelmax_OutHigh, 0);
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        repeat (4) step(1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
